pm_tdc_sens_reg_bank: RTL

Multi-channel successor to the single-channel TDC control/sensor data register in the power-management test-debug controller. One TAP-driven shift chain serves NUM_CH parallel control registers, with the target channel latched at capture. Each channel has its own write/load paths and live sensor tracking on any bits selected by SENS_MASK. A sticky per-channel change flag, cleared on read, records sensor-driven changes.

---
 rtl/pm_tdc_sens_reg_bank_if.sv | 31 +++
 rtl/pm_tdc_sens_reg_bank.sv | 102 ++++++++++
 2 files changed

// File: rtl/pm_tdc_sens_reg_bank_if.sv
// Bus bundle for the multi-channel TDC control/sensor register bank: TAP DR
// controls, shift chain and the packed per-channel parallel/load/status paths.
interface pm_tdc_sens_reg_bank_if #(
  parameter int DR_LENGTH = 16,
  parameter int NUM_CH    = 4,
  parameter int CH_SEL_W  = 2
);
  logic                          serial_in;
  logic                          serial_out;
  logic                          capture;
  logic                          shift;
  logic                          update;
  logic [CH_SEL_W-1:0]           ch_sel;
  logic [NUM_CH-1:0]             write;
  logic [NUM_CH*DR_LENGTH-1:0]   parallel_in;
  logic [NUM_CH-1:0]             load;
  logic [NUM_CH*DR_LENGTH-1:0]   load_data;
  logic [NUM_CH*DR_LENGTH-1:0]   parallel_out;
  logic [NUM_CH-1:0]             change_flag;
  logic                          sel_err;

  modport master (
    output serial_in, capture, shift, update, ch_sel, write, parallel_in, load, load_data,
    input  serial_out, parallel_out, change_flag, sel_err
  );

  modport slave (
    input  serial_in, capture, shift, update, ch_sel, write, parallel_in, load, load_data,
    output serial_out, parallel_out, change_flag, sel_err
  );
endinterface

// File: rtl/pm_tdc_sens_reg_bank.sv
// NUM_CH control registers behind one TAP shift chain; each channel tracks
// SENS_MASK bits of its sensor input live and flags sensor-driven changes.
module pm_tdc_sens_reg_bank #(
  parameter int                   DR_LENGTH   = 16,
  parameter int                   NUM_CH      = 4,
  parameter int                   CH_SEL_W    = 2,
  parameter logic [DR_LENGTH-1:0] RESET_VALUE = {DR_LENGTH{1'b0}},
  parameter logic [DR_LENGTH-1:0] SENS_MASK   = 16'h0400
) (
  input logic                     clk,
  input logic                     rst,
  pm_tdc_sens_reg_bank_if.slave   bus
);

  logic [DR_LENGTH-1:0]        chain_q;
  logic [CH_SEL_W-1:0]         active_ch_q;
  logic                        sel_err_q;
  logic [DR_LENGTH-1:0]        cap_val;
  logic                        sel_ok;
  logic [NUM_CH*DR_LENGTH-1:0] out_flat;
  logic [NUM_CH-1:0]           flag_flat;

  // Out-of-range selects capture zeros and raise sel_err.
  always_comb begin
    cap_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(bus.ch_sel) == c) cap_val = out_flat[c*DR_LENGTH +: DR_LENGTH];
    end
  end

  assign sel_ok = int'(bus.ch_sel) < NUM_CH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q     <= RESET_VALUE;
      active_ch_q <= '0;
      sel_err_q   <= 1'b0;
    end else if (bus.capture) begin
      active_ch_q <= bus.ch_sel;
      chain_q     <= cap_val;
      sel_err_q   <= !sel_ok;
    end else if (bus.shift) begin
      chain_q <= {bus.serial_in, chain_q[DR_LENGTH-1:1]};
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DR_LENGTH-1:0] out_q;
    logic [DR_LENGTH-1:0] snap_q;
    logic                 flag_q;
    logic [DR_LENGTH-1:0] ld;
    logic [DR_LENGTH-1:0] pin;
    logic [DR_LENGTH-1:0] diff;
    logic [DR_LENGTH-1:0] track_nxt;
    logic                 upd_hit;
    logic                 sens_step;
    logic                 sens_chg;

    assign ld        = bus.load_data[c*DR_LENGTH +: DR_LENGTH];
    assign pin       = bus.parallel_in[c*DR_LENGTH +: DR_LENGTH];
    assign upd_hit   = bus.update && !sel_err_q && (int'(active_ch_q) == c);
    assign sens_step = !upd_hit && !bus.write[c] && !bus.load[c];
    // Masked bits that disagree with the snapshot follow the live sensor.
    assign diff      = SENS_MASK & (ld ^ snap_q);
    assign track_nxt = (out_q & ~diff) | (ld & diff);
    assign sens_chg  = sens_step && (track_nxt != out_q);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_q  <= RESET_VALUE;
        snap_q <= RESET_VALUE;
        flag_q <= 1'b0;
      end else begin
        if (upd_hit) begin
          out_q <= chain_q;
        end else if (bus.write[c]) begin
          out_q <= pin;
        end else if (bus.load[c]) begin
          out_q  <= ld;
          snap_q <= ld;
        end else begin
          out_q <= track_nxt;
        end

        if (sens_chg) begin
          flag_q <= 1'b1;
        end else if (bus.capture && (int'(bus.ch_sel) == c)) begin
          flag_q <= 1'b0;
        end
      end
    end

    assign out_flat[c*DR_LENGTH +: DR_LENGTH] = out_q;
    assign flag_flat[c]                       = flag_q;
  end

  assign bus.serial_out   = chain_q[0];
  assign bus.parallel_out = out_flat;
  assign bus.change_flag  = flag_flat;
  assign bus.sel_err      = sel_err_q;

endmodule
